mem_wb_skid: RTL and testbench
==============================

Name: mem_wb_skid

Overview:
Parametrised successor to the fixed MEM/WB pipeline register. It carries one GPR write-back and one CSR write-back per instruction, and replaces the global stall vector with a valid/ready handshake backed by a 2-entry skid buffer. It adds a synchronous flush, optional x0-write suppression, a combinational forwarding lookup over held entries, and a retire counter. It sits between the MEM stage and the register-file/CSR write ports.

Parameters:
DATA_W, 32, width of GPR and CSR write data
REG_AW, 5, GPR address width
CSR_AW, 12, CSR address width
ZERO_SUPPRESS, 1, when 1 a GPR write to address 0 enters with we forced to 0
CNT_W, 32, retire counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous flush; discards all held entries
in_valid  in  1  MEM stage presents an entry
in_ready  out  1  block can accept an entry; registered
in_reg_waddr  in  REG_AW  GPR destination
in_reg_we  in  1  GPR write enable
in_reg_wdata  in  DATA_W  GPR data
in_csr_waddr  in  CSR_AW  CSR destination
in_csr_we  in  1  CSR write enable
in_csr_wdata  in  DATA_W  CSR data
out_valid  out  1  head entry valid
out_ready  in  1  write-back consumes head entry
out_reg_waddr  out  REG_AW  head GPR address
out_reg_we  out  1  head GPR write enable, gated by out_valid
out_reg_wdata  out  DATA_W  head GPR data
out_csr_waddr  out  CSR_AW  head CSR address
out_csr_we  out  1  head CSR write enable, gated by out_valid
out_csr_wdata  out  DATA_W  head CSR data
fwd_raddr  in  REG_AW  forwarding lookup address
fwd_hit  out  1  a held valid entry writes fwd_raddr
fwd_data  out  DATA_W  data of the youngest matching entry
retire_cnt  out  CNT_W  number of entries delivered

Behaviour:
- Storage: head register H (drives outputs) and skid register S; each has a valid bit, hv and sv.
- Handshake terms: accept = in_valid & in_ready; deliver = hv & out_ready.
- out_valid = hv. out_reg_we = hv & H.reg_we. out_csr_we = hv & H.csr_we. Address/data outputs hold their last loaded value when hv=0.
- in_ready is a register, next value = !sv_next. Reset value 1.
- H update occurs when deliver | !hv:
  - sv=1: H <= S, sv <= 0.
  - sv=0 and accept: H <= input.
  - otherwise: hv <= 0.
- S update: when hv & !out_ready & accept, S <= input and sv <= 1.
- accept while sv=1 cannot occur because in_ready=0; no third slot exists.
- Latency: an input accepted at edge N is visible on the outputs after edge N. Throughput is 1 per cycle with out_ready held high.
- ZERO_SUPPRESS=1: an input with in_reg_waddr==0 is captured with reg_we=0. Address and data are captured unchanged.
- flush=1 at an edge: hv<=0, sv<=0, in_ready<=1. Any accept and any deliver in that cycle are discarded, and retire_cnt does not increment. Flush takes priority over all other updates.
- Forwarding (combinational):
  - If sv & S.reg_we & S.reg_waddr==fwd_raddr, then hit with S.reg_wdata.
  - Else if hv & H.reg_we & H.reg_waddr==fwd_raddr, then hit with H.reg_wdata.
  - Else fwd_hit=0 and fwd_data=0.
  - With ZERO_SUPPRESS=1, fwd_raddr==0 never hits.
- retire_cnt increments by 1 on each deliver that is not flushed. It wraps modulo 2^CNT_W and is cleared only by rst.
- Reset values (asynchronous, immediate): hv=0, sv=0, in_ready=1, retire_cnt=0, all H/S payload fields 0. Therefore all outputs are 0 except in_ready=1.
- Reset asserted mid-transfer drops all entries without a delivery.

Test Plan:
1. Reset, then stream 4 entries with out_ready=1 (reg_waddr 1..4, wdata 0x10..0x40) -> each appears one cycle after accept; in_ready stays 1; retire_cnt=4.
2. Hold out_ready=0 and offer 3 entries A,B,C -> A held in H, B in S, in_ready=0 after B, C not accepted. Raise out_ready -> A, then B, then C (after re-accept) delivered in order, nothing lost or duplicated.
3. H and S both valid with reg_waddr=7, data 0x11 (H) and 0x22 (S); fwd_raddr=7 -> fwd_hit=1, fwd_data=0x22. Deliver H and S, then fwd_raddr=7 -> fwd_hit=0, fwd_data=0.
4. Input reg_waddr=0, reg_we=1, wdata 0xDEAD with ZERO_SUPPRESS=1 -> out_valid=1, out_reg_we=0; fwd_raddr=0 -> fwd_hit=0.
5. H and S full, flush=1 together with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, retire_cnt unchanged.
6. Assert rst asynchronously mid-stream, between edges -> outputs go to 0 and in_ready to 1 immediately. Preload retire_cnt to 2^CNT_W-1 (CNT_W=4 build), then one deliver -> retire_cnt wraps to 0.

Source files
------------

// File: rtl/mem_wb_skid.sv
// mem_wb_skid: MEM/WB register with valid/ready handshake, 2-entry skid buffer, flush, forwarding and retire counter
module mem_wb_skid #(
    parameter int DATA_W        = 32,
    parameter int REG_AW        = 5,
    parameter int CSR_AW        = 12,
    parameter int ZERO_SUPPRESS = 1,
    parameter int CNT_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_reg_waddr,
    input  logic              in_reg_we,
    input  logic [DATA_W-1:0] in_reg_wdata,
    input  logic [CSR_AW-1:0] in_csr_waddr,
    input  logic              in_csr_we,
    input  logic [DATA_W-1:0] in_csr_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_reg_waddr,
    output logic              out_reg_we,
    output logic [DATA_W-1:0] out_reg_wdata,
    output logic [CSR_AW-1:0] out_csr_waddr,
    output logic              out_csr_we,
    output logic [DATA_W-1:0] out_csr_wdata,
    input  logic [REG_AW-1:0] fwd_raddr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retire_cnt
);
    typedef struct packed {
        logic [REG_AW-1:0] ra;
        logic              rwe;
        logic [DATA_W-1:0] rd;
        logic [CSR_AW-1:0] ca;
        logic              cwe;
        logic [DATA_W-1:0] cd;
    } entry_t;

    entry_t h, s, in_e;
    logic   hv, sv, sv_next, accept, deliver, s_hit, h_hit;

    assign accept  = in_valid & in_ready;
    assign deliver = hv & out_ready;

    // incoming entry with x0 writes optionally stripped of their enable
    always_comb begin
        in_e     = '{in_reg_waddr, in_reg_we, in_reg_wdata, in_csr_waddr, in_csr_we, in_csr_wdata};
        in_e.rwe = in_reg_we & !((ZERO_SUPPRESS != 0) && (in_reg_waddr == '0));
    end

    // skid occupancy after this edge; drives the registered in_ready
    always_comb begin
        sv_next = flush ? 1'b0 :
                  ((deliver | !hv) & sv) ? 1'b0 :
                  (hv & !out_ready & accept) ? 1'b1 : sv;
    end

    // head/skid storage; flush drops both slots but keeps stale payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h        <= '0;
            s        <= '0;
            hv       <= 1'b0;
            sv       <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            sv       <= sv_next;
            in_ready <= !sv_next;
            if (flush) begin
                hv <= 1'b0;
            end else begin
                if (deliver | !hv) begin
                    if (sv) begin
                        h  <= s;
                        hv <= 1'b1;
                    end else if (accept) begin
                        h  <= in_e;
                        hv <= 1'b1;
                    end else begin
                        hv <= 1'b0;
                    end
                end
                if (hv & !out_ready & accept)
                    s <= in_e;
            end
        end
    end

    // count non-flushed deliveries, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retire_cnt <= '0;
        else if (!flush && deliver)
            retire_cnt <= retire_cnt + 1'b1;
    end

    assign out_valid     = hv;
    assign out_reg_waddr = h.ra;
    assign out_reg_we    = hv & h.rwe;
    assign out_reg_wdata = h.rd;
    assign out_csr_waddr = h.ca;
    assign out_csr_we    = hv & h.cwe;
    assign out_csr_wdata = h.cd;

    // forwarding: skid entry is younger than head, so it wins
    always_comb begin
        s_hit    = sv & s.rwe & (s.ra == fwd_raddr);
        h_hit    = hv & h.rwe & (h.ra == fwd_raddr);
        fwd_hit  = s_hit | h_hit;
        fwd_data = s_hit ? s.rd : h_hit ? h.rd : '0;
    end
endmodule

// File: tb/tb_mem_wb_skid.sv
// tb_mem_wb_skid: directed table-driven bench for mem_wb_skid
module tb_mem_wb_skid;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_reg_we, in_csr_we;
    logic        out_valid, out_ready, out_reg_we, out_csr_we, fwd_hit;
    logic [4:0]  in_reg_waddr, out_reg_waddr, fwd_raddr;
    logic [11:0] in_csr_waddr, out_csr_waddr;
    logic [31:0] in_reg_wdata, in_csr_wdata, out_reg_wdata, out_csr_wdata, fwd_data;
    logic [3:0]  retire_cnt;
    int          checks = 0;
    int          errors = 0;

    mem_wb_skid #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_waddr(in_reg_waddr), .in_reg_we(in_reg_we), .in_reg_wdata(in_reg_wdata),
        .in_csr_waddr(in_csr_waddr), .in_csr_we(in_csr_we), .in_csr_wdata(in_csr_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_reg_waddr(out_reg_waddr), .out_reg_we(out_reg_we), .out_reg_wdata(out_reg_wdata),
        .out_csr_waddr(out_csr_waddr), .out_csr_we(out_csr_we), .out_csr_wdata(out_csr_wdata),
        .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl, iv, rwe, cwe, ordy;
        logic [4:0]  ra, fa;
        logic [31:0] rd;
        logic        ov, ir, erwe, ecwe, hit;
        logic [4:0]  era;
        logic [31:0] erd, efd;
        logic [3:0]  cnt;
    } vec_t;

    vec_t v[26];

    function automatic vec_t mk(input int fl, iv, ra, rwe, rd, cwe, ordy, fa,
                                input int ov, ir, era, erwe, erd, ecwe, hit, efd, cnt);
        vec_t r;
        r.fl = 1'(fl); r.iv = 1'(iv); r.ra = 5'(ra); r.rwe = 1'(rwe); r.rd = 32'(rd);
        r.cwe = 1'(cwe); r.ordy = 1'(ordy); r.fa = 5'(fa);
        r.ov = 1'(ov); r.ir = 1'(ir); r.era = 5'(era); r.erwe = 1'(erwe); r.erd = 32'(erd);
        r.ecwe = 1'(ecwe); r.hit = 1'(hit); r.efd = 32'(efd); r.cnt = 4'(cnt);
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic fl, iv, input logic [4:0] ra, input logic rwe,
                         input logic [31:0] rd, input logic cwe, ordy, input logic [4:0] fa);
        flush = fl; in_valid = iv; in_reg_waddr = ra; in_reg_we = rwe; in_reg_wdata = rd;
        in_csr_waddr = 12'(ra) + 12'h300; in_csr_we = cwe; in_csr_wdata = rd ^ 32'hFFFF0000;
        out_ready = ordy; fwd_raddr = fa;
    endtask

    task automatic chk_reset(input int idx);
        chk("rst_out_valid", idx, 32'(out_valid), 0);
        chk("rst_in_ready", idx, 32'(in_ready), 1);
        chk("rst_reg_waddr", idx, 32'(out_reg_waddr), 0);
        chk("rst_reg_we", idx, 32'(out_reg_we), 0);
        chk("rst_reg_wdata", idx, out_reg_wdata, 0);
        chk("rst_csr_waddr", idx, 32'(out_csr_waddr), 0);
        chk("rst_csr_we", idx, 32'(out_csr_we), 0);
        chk("rst_csr_wdata", idx, out_csr_wdata, 0);
        chk("rst_fwd_hit", idx, 32'(fwd_hit), 0);
        chk("rst_fwd_data", idx, fwd_data, 0);
        chk("rst_retire_cnt", idx, 32'(retire_cnt), 0);
    endtask

    initial begin
        //         fl iv ra rwe rd      cwe or fa | ov ir era erwe erd    ecwe hit efd    cnt
        v[0]  = mk(0, 1, 1, 1, 'h10,   1, 1, 1,   1, 1, 1, 1, 'h10,   1, 1, 'h10,  0);
        v[1]  = mk(0, 1, 2, 1, 'h20,   1, 1, 1,   1, 1, 2, 1, 'h20,   1, 0, 0,     1);
        v[2]  = mk(0, 1, 3, 1, 'h30,   1, 1, 3,   1, 1, 3, 1, 'h30,   1, 1, 'h30,  2);
        v[3]  = mk(0, 1, 4, 1, 'h40,   1, 1, 0,   1, 1, 4, 1, 'h40,   1, 0, 0,     3);
        v[4]  = mk(0, 0, 0, 0, 0,      0, 1, 4,   0, 1, 4, 0, 'h40,   0, 0, 0,     4);
        v[5]  = mk(0, 1, 5, 1, 'hA0,   0, 0, 5,   1, 1, 5, 1, 'hA0,   0, 1, 'hA0,  4);
        v[6]  = mk(0, 1, 6, 1, 'hB0,   1, 0, 5,   1, 0, 5, 1, 'hA0,   0, 1, 'hA0,  4);
        v[7]  = mk(0, 1, 7, 1, 'hC0,   1, 0, 6,   1, 0, 5, 1, 'hA0,   0, 1, 'hB0,  4);
        v[8]  = mk(0, 1, 7, 1, 'hC0,   1, 1, 6,   1, 1, 6, 1, 'hB0,   1, 1, 'hB0,  5);
        v[9]  = mk(0, 1, 7, 1, 'hC0,   1, 1, 7,   1, 1, 7, 1, 'hC0,   1, 1, 'hC0,  6);
        v[10] = mk(0, 0, 0, 0, 0,      0, 1, 0,   0, 1, 7, 0, 'hC0,   0, 0, 0,     7);
        v[11] = mk(0, 1, 7, 1, 'h11,   0, 0, 7,   1, 1, 7, 1, 'h11,   0, 1, 'h11,  7);
        v[12] = mk(0, 1, 7, 1, 'h22,   0, 0, 7,   1, 0, 7, 1, 'h11,   0, 1, 'h22,  7);
        v[13] = mk(0, 0, 0, 0, 0,      0, 1, 7,   1, 1, 7, 1, 'h22,   0, 1, 'h22,  8);
        v[14] = mk(0, 0, 0, 0, 0,      0, 1, 7,   0, 1, 7, 0, 'h22,   0, 0, 0,     9);
        v[15] = mk(0, 1, 0, 1, 'hDEAD, 1, 0, 0,   1, 1, 0, 0, 'hDEAD, 1, 0, 0,     9);
        v[16] = mk(0, 1, 3, 0, 'h33,   0, 1, 3,   1, 1, 3, 0, 'h33,   0, 0, 0,     10);
        v[17] = mk(0, 1, 8, 1, 'h80,   1, 0, 8,   1, 0, 3, 0, 'h33,   0, 1, 'h80,  10);
        v[18] = mk(1, 1, 9, 1, 'h90,   1, 1, 8,   0, 1, 3, 0, 'h33,   0, 0, 0,     10);
        v[19] = mk(0, 1, 10, 1, 'hAA0, 1, 1, 10,  1, 1, 10, 1, 'hAA0, 1, 1, 'hAA0, 10);
        v[20] = mk(0, 1, 11, 1, 'hB0B, 1, 1, 0,   1, 1, 11, 1, 'hB0B, 1, 0, 0,     11);
        v[21] = mk(0, 1, 12, 1, 'hC0C, 1, 1, 0,   1, 1, 12, 1, 'hC0C, 1, 0, 0,     12);
        v[22] = mk(0, 1, 13, 1, 'hD0D, 1, 1, 0,   1, 1, 13, 1, 'hD0D, 1, 0, 0,     13);
        v[23] = mk(0, 1, 14, 1, 'hE0E, 1, 1, 0,   1, 1, 14, 1, 'hE0E, 1, 0, 0,     14);
        v[24] = mk(0, 1, 15, 1, 'hF0F, 1, 1, 0,   1, 1, 15, 1, 'hF0F, 1, 0, 0,     15);
        v[25] = mk(0, 0, 0, 0, 0,      0, 1, 0,   0, 1, 15, 0, 'hF0F, 0, 0, 0,     0);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk_reset(0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            drive(v[i].fl, v[i].iv, v[i].ra, v[i].rwe, v[i].rd, v[i].cwe, v[i].ordy, v[i].fa);
            @(posedge clk);
            #1;
            chk("out_valid", i, 32'(out_valid), 32'(v[i].ov));
            chk("in_ready", i, 32'(in_ready), 32'(v[i].ir));
            chk("reg_waddr", i, 32'(out_reg_waddr), 32'(v[i].era));
            chk("reg_we", i, 32'(out_reg_we), 32'(v[i].erwe));
            chk("reg_wdata", i, out_reg_wdata, v[i].erd);
            chk("csr_waddr", i, 32'(out_csr_waddr), 32'(12'(v[i].era) + 12'h300));
            chk("csr_we", i, 32'(out_csr_we), 32'(v[i].ecwe));
            chk("csr_wdata", i, out_csr_wdata, v[i].erd ^ 32'hFFFF0000);
            chk("fwd_hit", i, 32'(fwd_hit), 32'(v[i].hit));
            chk("fwd_data", i, fwd_data, v[i].efd);
            chk("retire_cnt", i, 32'(retire_cnt), 32'(v[i].cnt));
        end

        @(negedge clk);
        drive(0, 1, 20, 1, 'h140, 1, 1, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1, 21, 1, 'h150, 1, 1, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1, 22, 1, 'h160, 1, 0, 22);
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", 100, 32'(out_valid), 1);
        chk("pre_rst_in_ready", 100, 32'(in_ready), 0);
        chk("pre_rst_retire_cnt", 100, 32'(retire_cnt), 1);
        chk("pre_rst_fwd_data", 100, fwd_data, 'h160);
        #1;
        rst = 1'b1;
        #1;
        chk_reset(101);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 102, 32'(out_valid), 0);
        chk("post_rst_in_ready", 102, 32'(in_ready), 1);
        chk("post_rst_retire_cnt", 102, 32'(retire_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
